// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the RV32I branch-prediction slice.
//   rv32i_brp_word - prediction word handed to fetch (predicted, prediction,
//                    mispredicted, brp_target, brp_alt).
//   pht_cnt_t      - 2-bit saturating pattern-history counter, with its
//                    reset value (weakly not-taken) and its saturation limits.
//   btb_entry_t    - payload of one direct-mapped BTB line; the valid bit is
//                    kept in a separate vector so it can be reset.
package rv32i_types;

    typedef struct packed {
        logic        predicted;     // BTB hit for this PC
        logic        prediction;    // predicted taken
        logic        mispredicted;  // always 0 at prediction time
        logic [31:0] brp_target;    // next fetch PC
        logic [31:0] brp_alt;       // the path not chosen
    } rv32i_brp_word;

    typedef logic [1:0] pht_cnt_t;

    localparam pht_cnt_t PHT_CNT_RST = 2'b01;
    localparam pht_cnt_t PHT_CNT_MAX = 2'b11;
    localparam pht_cnt_t PHT_CNT_MIN = 2'b00;

    // The tag field is sized for the smallest possible index; narrower tags
    // are zero-extended so every stored bit takes part in the compare.
    typedef struct packed {
        logic        jump;
        logic [29:0] tag;
        logic [31:0] target;
    } btb_entry_t;

endpackage

// File: rtl/brp_gshare_btb_if.sv
// brp_gshare_btb_if: fetch-side lookup and EX-side update signals of the
// branch predictor.
//   master - core side: drives pred_req/pc_if and the upd_* resolve bus,
//            receives pred_out/pred_ghr.
//   slave  - predictor side.
interface brp_gshare_btb_if #(
    parameter int GHR_W = 8
) ();
    import rv32i_types::*;

    logic               pred_req;
    logic [31:0]        pc_if;
    rv32i_brp_word      pred_out;
    logic [GHR_W-1:0]   pred_ghr;

    logic               upd_valid;
    logic [31:0]        upd_pc;
    logic [31:0]        upd_target;
    logic               upd_is_jump;
    logic               upd_taken;
    logic               upd_mispredict;
    logic [GHR_W-1:0]   upd_ghr;

    modport master (
        output pred_req, pc_if,
        output upd_valid, upd_pc, upd_target, upd_is_jump, upd_taken,
               upd_mispredict, upd_ghr,
        input  pred_out, pred_ghr
    );

    modport slave (
        input  pred_req, pc_if,
        input  upd_valid, upd_pc, upd_target, upd_is_jump, upd_taken,
               upd_mispredict, upd_ghr,
        output pred_out, pred_ghr
    );

endinterface

// File: rtl/brp_sat_counter.sv
// brp_sat_counter: next value of a 2-bit pattern-history counter.
//   cnt_in  - current counter
//   inc     - 1: count toward taken, 0: count toward not-taken
//   cnt_out - updated counter, saturating at 3 and 0
module brp_sat_counter
    import rv32i_types::*;
(
    input  pht_cnt_t cnt_in,
    input  logic     inc,
    output pht_cnt_t cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (inc) begin
            if (cnt_in != PHT_CNT_MAX) cnt_out = cnt_in + 2'd1;
        end else begin
            if (cnt_in != PHT_CNT_MIN) cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/brp_gshare_btb.sv
// brp_gshare_btb: direct-mapped BTB plus 2-bit PHT with a speculative global
// history register.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - brp_gshare_btb_if.slave: combinational lookup of pc_if
//                (pred_out, pred_ghr) and the resolved-branch update bus.
// Build option: define BRP_GSHARE_HASH_EN to index the PHT with
// pc[PHT_IDX_W+1:2] XOR the history; without it the PHT is bimodal
// (PC bits only) while the GHR is still maintained and reported.
module brp_gshare_btb
    import rv32i_types::*;
#(
    parameter int GHR_W     = 8,
    parameter int PHT_IDX_W = 8,
    parameter int BTB_IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    brp_gshare_btb_if.slave    bus
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int PHT_N = 1 << PHT_IDX_W;

    logic [BTB_N-1:0]     btb_valid;
    btb_entry_t           btb_mem [BTB_N];
    pht_cnt_t             pht     [PHT_N];
    logic [GHR_W-1:0]     ghr;
    logic [GHR_W-1:0]     ghr_next;

    logic [BTB_IDX_W-1:0] lk_btb_idx, up_btb_idx;
    logic [PHT_IDX_W-1:0] lk_pht_idx, up_pht_idx;
    btb_entry_t           lk_entry, up_entry;
    logic                 lk_hit, lk_taken, up_hit;
    logic [31:0]          lk_fall;
    rv32i_brp_word        pred;
    pht_cnt_t             up_cnt_next;
    logic                 unused_pc_lsbs;

    function automatic logic [29:0] tag_of(input logic [31:0] pc);
        return 30'(pc[31:BTB_IDX_W+2]);
    endfunction

    assign unused_pc_lsbs = ^{bus.upd_pc[1:0]};

    assign lk_btb_idx = bus.pc_if[BTB_IDX_W+1:2];
    assign up_btb_idx = bus.upd_pc[BTB_IDX_W+1:2];

`ifdef BRP_GSHARE_HASH_EN
    assign lk_pht_idx = bus.pc_if[PHT_IDX_W+1:2]  ^ PHT_IDX_W'(ghr);
    assign up_pht_idx = bus.upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bus.upd_ghr);
`else
    assign lk_pht_idx = bus.pc_if[PHT_IDX_W+1:2];
    assign up_pht_idx = bus.upd_pc[PHT_IDX_W+1:2];
`endif

    // Lookup reads the arrays as they stand this cycle; a same-cycle update
    // becomes visible only after the next edge.
    always_comb begin
        lk_entry = btb_mem[lk_btb_idx];
        lk_hit   = btb_valid[lk_btb_idx] && (lk_entry.tag == tag_of(bus.pc_if));
        lk_taken = lk_hit && (lk_entry.jump || pht[lk_pht_idx][1]);
        lk_fall  = bus.pc_if + 32'd4;

        pred              = '0;
        pred.predicted    = lk_hit;
        pred.prediction   = lk_taken;
        pred.mispredicted = 1'b0;
        pred.brp_target   = lk_fall;
        pred.brp_alt      = lk_fall;
        if (lk_taken) begin
            pred.brp_target = lk_entry.target;
        end else if (lk_hit) begin
            pred.brp_alt = lk_entry.target;
        end
    end

    assign bus.pred_out = pred;
    assign bus.pred_ghr = ghr;

    always_comb begin
        up_entry = btb_mem[up_btb_idx];
        up_hit   = btb_valid[up_btb_idx] && (up_entry.tag == tag_of(bus.upd_pc));
    end

    brp_sat_counter u_sat (
        .cnt_in  (pht[up_pht_idx]),
        .inc     (bus.upd_taken),
        .cnt_out (up_cnt_next)
    );

    // A misprediction repair restores the history the resolving instruction
    // saw and wins over any speculative shift from this cycle's lookup.
    always_comb begin
        ghr_next = ghr;
        if (bus.upd_valid && bus.upd_mispredict) begin
            if (bus.upd_is_jump) ghr_next = bus.upd_ghr;
            else                 ghr_next = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
        end else if (bus.pred_req && lk_hit && !lk_entry.jump) begin
            ghr_next = {ghr[GHR_W-2:0], lk_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr       <= '0;
            btb_valid <= '0;
            for (int i = 0; i < PHT_N; i++) pht[i] <= PHT_CNT_RST;
        end else begin
            ghr <= ghr_next;
            if (bus.upd_valid && bus.upd_taken)
                btb_valid[up_btb_idx] <= 1'b1;
            if (bus.upd_valid && !bus.upd_is_jump)
                pht[up_pht_idx] <= up_cnt_next;
        end
    end

    // Line payload has no reset; it is qualified by btb_valid. A not-taken
    // branch never allocates, but a line it already owns is re-marked as a
    // conditional branch so its direction comes from the PHT. The target is
    // kept because the resolved target of a not-taken branch is the
    // fall-through.
    always_ff @(posedge clk) begin
        if (rst_n && bus.upd_valid) begin
            if (bus.upd_taken) begin
                btb_mem[up_btb_idx] <= '{jump:   bus.upd_is_jump,
                                         tag:    tag_of(bus.upd_pc),
                                         target: bus.upd_target};
            end else if (!bus.upd_is_jump && up_hit) begin
                btb_mem[up_btb_idx].jump <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_brp_gshare_btb.sv
module tb_brp_gshare_btb;

    localparam int GHR_W = 8;
`ifdef BRP_GSHARE_HASH_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    brp_gshare_btb_if #(.GHR_W(GHR_W)) bus ();

    brp_gshare_btb #(.GHR_W(GHR_W), .PHT_IDX_W(8), .BTB_IDX_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: what each BTB line holds and each PHT counter's value.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    bit          m_jump  [64];
    int          m_pht   [256];
    int unsigned m_ghr;

    // Hand-computed expectation for the current cycle, if any.
    bit          lit_en = 1'b0;
    string       lit_name = "";
    bit          lit_pd, lit_pn, lit_ghr_en;
    int unsigned lit_tgt, lit_alt, lit_ghr;

    function automatic int unsigned pht_index(int unsigned pc, int unsigned hist);
        return ((pc >> 2) ^ (GSHARE ? hist : 0)) & 255;
    endfunction

    function automatic int unsigned btb_index(int unsigned pc);
        return (pc >> 2) & 63;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_ghr = 0;
    endtask

    always @(negedge clk) begin : compare
        int unsigned pc, bi, e_tgt, e_alt, upc, ui, ug, new_ghr;
        bit          e_hit, e_taken, u_hit, ok;
        if (!rst_n) model_reset();

        pc      = bus.pc_if;
        bi      = btb_index(pc);
        e_hit   = m_valid[bi] && (m_tag[bi] == (pc >> 8));
        e_taken = e_hit && (m_jump[bi] || m_pht[pht_index(pc, m_ghr)] >= 2);
        e_tgt   = e_taken ? m_tgt[bi] : pc + 4;
        e_alt   = e_taken ? pc + 4 : (e_hit ? m_tgt[bi] : pc + 4);

        ok = (bus.pred_out.predicted === e_hit) && (bus.pred_out.prediction === e_taken) &&
             (bus.pred_out.mispredicted === 1'b0) && (bus.pred_out.brp_target === e_tgt) &&
             (bus.pred_out.brp_alt === e_alt) && (bus.pred_ghr === m_ghr[7:0]);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL model t=%0t pc=%h got pd=%b pn=%b mp=%b tgt=%h alt=%h ghr=%h want pd=%b pn=%b tgt=%h alt=%h ghr=%h",
                      $time, pc, bus.pred_out.predicted, bus.pred_out.prediction,
                      bus.pred_out.mispredicted, bus.pred_out.brp_target, bus.pred_out.brp_alt,
                      bus.pred_ghr, e_hit, e_taken, e_tgt, e_alt, m_ghr[7:0]);

        if (lit_en) begin
            ok = (bus.pred_out.predicted === lit_pd) && (bus.pred_out.prediction === lit_pn) &&
                 (bus.pred_out.brp_target === lit_tgt) && (bus.pred_out.brp_alt === lit_alt) &&
                 (!lit_ghr_en || bus.pred_ghr === lit_ghr[7:0]);
            n_total++;
            if (ok) n_pass++;
            else $display("FAIL %s got pd=%b pn=%b tgt=%h alt=%h ghr=%h want pd=%b pn=%b tgt=%h alt=%h ghr=%h",
                          lit_name, bus.pred_out.predicted, bus.pred_out.prediction,
                          bus.pred_out.brp_target, bus.pred_out.brp_alt, bus.pred_ghr,
                          lit_pd, lit_pn, lit_tgt, lit_alt, lit_ghr[7:0]);
        end

        // Advance the reference by the edge that will sample these inputs.
        if (rst_n) begin
            new_ghr = m_ghr;
            if (bus.upd_valid && bus.upd_mispredict)
                new_ghr = bus.upd_is_jump ? bus.upd_ghr : (((bus.upd_ghr << 1) | bus.upd_taken) & 255);
            else if (bus.pred_req && e_hit && !m_jump[bi])
                new_ghr = ((m_ghr << 1) | e_taken) & 255;

            upc   = bus.upd_pc;
            ui    = btb_index(upc);
            ug    = bus.upd_ghr;
            u_hit = m_valid[ui] && (m_tag[ui] == (upc >> 8));
            if (bus.upd_valid && !bus.upd_is_jump) begin
                if (bus.upd_taken) m_pht[pht_index(upc, ug)] = (m_pht[pht_index(upc, ug)] == 3) ? 3 : m_pht[pht_index(upc, ug)] + 1;
                else               m_pht[pht_index(upc, ug)] = (m_pht[pht_index(upc, ug)] == 0) ? 0 : m_pht[pht_index(upc, ug)] - 1;
            end
            if (bus.upd_valid && bus.upd_taken) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = upc >> 8;
                m_tgt[ui]   = bus.upd_target;
                m_jump[ui]  = bus.upd_is_jump;
            end else if (bus.upd_valid && !bus.upd_is_jump && u_hit) begin
                m_jump[ui] = 1'b0;
            end
            m_ghr = new_ghr;
        end
    end

    task automatic idle();
        bus.pred_req       = 1'b0;
        bus.pc_if          = 32'h100;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = 32'h0;
        bus.upd_target     = 32'h0;
        bus.upd_is_jump    = 1'b0;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.upd_ghr        = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
        idle();
    endtask

    task automatic lookup(input logic [31:0] pc, input logic req);
        bus.pc_if    = pc;
        bus.pred_req = req;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic jump,
                          input logic taken, input logic mis, input logic [7:0] ghr);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_target     = tgt;
        bus.upd_is_jump    = jump;
        bus.upd_taken      = taken;
        bus.upd_mispredict = mis;
        bus.upd_ghr        = ghr;
    endtask

    task automatic expect_lit(input string name, input bit pd, input bit pn,
                              input int unsigned tgt, input int unsigned alt,
                              input bit ghr_en, input int unsigned ghr);
        lit_name = name; lit_pd = pd; lit_pn = pn; lit_tgt = tgt; lit_alt = alt;
        lit_ghr_en = ghr_en; lit_ghr = ghr; lit_en = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        expect_lit("reset_outputs", 0, 0, 32'h104, 32'h104, 1, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        tick(); lookup(32'h100, 1);
        expect_lit("cold_miss_0x100", 0, 0, 32'h104, 32'h104, 1, 0);

        tick(); update(32'h100, 32'h200, 1, 1, 1, 8'h00);
        tick(); lookup(32'h100, 1);
        expect_lit("jal_hit_0x100", 1, 1, 32'h200, 32'h104, 0, 0);

        tick(); update(32'h180, 32'h140, 0, 1, 1, 8'h00);
        tick(); update(32'h180, 32'h140, 0, 1, 0, 8'h01);
        tick(); lookup(32'h180, 0);
        expect_lit("branch_taken_twice", 1, 1, 32'h140, 32'h184, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); update(32'h180, 32'h184, 0, 0, 0, 8'h01);
        end
        tick(); lookup(32'h180, 0);
        expect_lit("branch_sat_low", 1, 0, 32'h184, 32'h140, 0, 0);

        tick(); lookup(32'h180, 1); update(32'h304, 32'h340, 0, 1, 1, 8'h0F);
        tick(); lookup(32'h104, 0);
        expect_lit("ghr_repair_wins", 0, 0, 32'h108, 32'h108, 1, 32'h1F);

        tick(); update(32'h100, 32'h200, 1, 1, 0, 8'h00);
        tick(); update(32'h200, 32'h400, 1, 1, 0, 8'h00);
        tick(); lookup(32'h100, 1);
        expect_lit("evicted_0x100", 0, 0, 32'h104, 32'h104, 0, 0);
        tick(); lookup(32'h200, 1);
        expect_lit("evictor_0x200", 1, 1, 32'h400, 32'h204, 0, 0);

        tick(); lookup(32'h500, 1); update(32'h500, 32'h600, 1, 1, 0, 8'h00);
        expect_lit("no_bypass_0x500", 0, 0, 32'h504, 32'h504, 0, 0);
        tick(); lookup(32'h500, 1);
        expect_lit("next_cycle_0x500", 1, 1, 32'h600, 32'h504, 0, 0);

        tick(); update(32'h700, 32'h800, 1, 1, 0, 8'h00);
        #2 rst_n = 1'b0;
        tick(); lookup(32'h700, 0);
        expect_lit("pending_upd_dropped", 0, 0, 32'h704, 32'h704, 1, 0);
        #1 rst_n = 1'b1;
        tick(); lookup(32'h200, 0);
        expect_lit("post_reset_miss", 0, 0, 32'h204, 32'h204, 1, 0);
        tick(); update(32'h180, 32'h140, 0, 1, 0, 8'h00);
        tick(); lookup(32'h180, 0);
        expect_lit("pht_back_to_01", 1, 1, 32'h140, 32'h184, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic j;
            tick();
            lookup(rand_pc(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                j = ($urandom_range(0, 3) == 0);
                update(rand_pc(), 32'($urandom) & 32'hFFC, j,
                       j ? 1'b1 : 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 8'($urandom));
            end
            if (i % 700 == 350) begin
                #2 rst_n = 1'b0;
                tick();
                lookup(rand_pc(), 1'b1);
                #1 rst_n = 1'b1;
            end
        end

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
